byte_serial_adder: RTL
======================

Name: byte_serial_adder

Overview:
- Byte-serial multi-word adder that feeds the team's 8-bit parallel-prefix adder core.
- Accepts two NUM_BYTES-wide operands one byte pair per beat, least significant byte first.
- Chains the carry between beats and emits one registered sum byte per beat.
- Flags the final byte and reports the carry-out of the full-width add with it.

Parameters:
- NUM_BYTES, 4: bytes per operand frame; legal range 1..256.
- CNT_W, max(1, clog2(NUM_BYTES)): byte-index counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; drops the partial frame and any pending output.
- in_valid  input  1  operand byte pair present.
- in_ready  output  1  block accepts the pair this cycle.
- in_a  input  8  operand A byte; bit 0 is the LSB.
- in_b  input  8  operand B byte; bit 0 is the LSB.
- out_valid  output  1  out_* registers hold a result byte.
- out_ready  input  1  downstream consumes the result this cycle.
- out_sum  output  8  sum byte, (in_a + in_b + carry_in) mod 256.
- out_last  output  1  out_sum is the frame's most significant byte.
- out_carry  output  1  full-width carry-out; valid only with out_last, 0 otherwise.
- busy  output  1  mid-frame (byte index != 0).

Behaviour:
- Reset (rst_n low, asynchronous) clears everything immediately:
  - out_valid=0, out_sum=0, out_last=0, out_carry=0, busy=0.
  - Byte index = 0, carry register = 0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, at the next clock edge:
  - out_sum <= low 8 bits of in_a + in_b + carry_reg.
  - cout = bit 8 of that add.
  - out_last <= (idx == NUM_BYTES-1).
  - out_carry <= cout if last, else 0.
  - out_valid <= 1.
  - carry_reg <= last ? 0 : cout.
  - idx <= last ? 0 : idx+1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 byte/cycle when out_ready is held high.
- Output handshake:
  - When out_valid && out_ready and there is no accept in the same cycle, out_valid <= 0.
  - When out_valid && !out_ready, all out_* hold stable and in_ready=0.
- Simultaneous pop and accept: the new result replaces the old one with no bubble.
- Carry never crosses a frame boundary. Byte 0 of every frame uses carry_in=0.
- NUM_BYTES=1: every beat is last; carry_reg stays 0.
- Wrap-around: idx returns to 0 after the last byte. There is no idle gap requirement between frames.
- clear (synchronous, highest priority over accept):
  - Next cycle: idx=0, carry_reg=0, out_valid=0, busy=0.
  - The beat presented in the clear cycle is discarded, even if in_ready=1.
  - out_sum, out_last and out_carry are forced to 0.
- Reset mid-frame: the partial frame is lost. The first accepted beat after rst_n deasserts is byte 0 with carry_in=0.
- busy = (idx != 0), driven from the register.
- in_a and in_b are not sampled unless there is an accept. X on the operand pins while in_valid=0 must not propagate.

Decomposition:
- Shared package holds:
  - BYTE_W = 8.
  - A byte_t typedef.
  - A sum_t struct {logic cout; byte_t sum}.
- One sub-module, add8_cin: a combinational 8-bit parallel-prefix adder with carry-in.
  - Ports: a[7:0], b[7:0], cin, sum[7:0], cout.
  - Same Ladner-Fischer generate/propagate structure as the existing 8-bit core.
  - cin is folded into bit-0 generate: g0 = a0&b0 | (a0^b0)&cin.
- byte_serial_adder holds only the counter, carry register, output register and handshake.

Test Plan:
- NUM_BYTES=4, A=0x000000FF, B=0x00000001, out_ready=1:
  - Outputs 00,01,00,00 on consecutive cycles.
  - out_last only on the 4th beat; out_carry=0.
- A=0xFFFFFFFF, B=0x00000001:
  - Outputs 00,00,00,00.
  - out_carry=1 with out_last. Back-to-back next frame 0x0+0x0 gives 00,00,00,00 with out_carry=0 (no carry leak).
- Backpressure: A=0x12345678, B=0x11111111, out_ready low for 3 cycles after the first result:
  - out_sum holds 0x89 and in_ready=0 throughout.
  - Resumed outputs are 67,45,23, with no beat lost or duplicated.
- clear after 2 accepted bytes of 0xFFFF+0x0001:
  - Next cycle out_valid=0 and busy=0.
  - A following frame 0x00000001+0x00000001 yields 02,00,00,00.
- rst_n pulsed low mid-frame (asynchronously, between edges):
  - out_valid and busy drop to 0 without waiting for a clock edge.
  - After release, a frame 0xFF+0x01 (NUM_BYTES=1 build) gives out_sum=00, out_last=1, out_carry=1.
- Random soak: 10k frames with random valid/ready gaps. Scoreboard checks full-width A+B and carry-out against a reference model.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// byte_serial_adder_pkg
//   Shared types for the byte-serial adder and its 8-bit prefix adder core.
//   BYTE_W : datapath width of one beat
//   byte_t : one operand / result byte
//   sum_t  : adder result, carry-out alongside the sum byte
package byte_serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef struct packed {
        logic  cout;
        byte_t sum;
    } sum_t;

endpackage

// File: rtl/byte_serial_adder_if.sv
// byte_serial_adder_if
//   Operand input stream and result output stream of the byte-serial adder.
//   Upstream:   in_valid, in_ready, in_a, in_b          (one byte pair per beat, LSB first)
//   Downstream: out_valid, out_ready, out_sum, out_last, out_carry
//   master : the side that produces operands and consumes results
//   slave  : the adder itself
interface byte_serial_adder_if;
    import byte_serial_adder_pkg::*;

    logic  in_valid;
    logic  in_ready;
    byte_t in_a;
    byte_t in_b;
    logic  out_valid;
    logic  out_ready;
    byte_t out_sum;
    logic  out_last;
    logic  out_carry;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_carry
    );

endinterface

// File: rtl/byte_serial_adder_add8_cin.sv
// add8_cin
//   Combinational 8-bit Ladner-Fischer parallel-prefix adder with carry-in.
//   a, b : operand bytes (bit 0 = LSB)
//   cin  : carry into bit 0
//   sum  : (a + b + cin) mod 256
//   cout : carry out of bit 7
//   Carry-in is folded into the bit-0 generate term, so every group
//   generate G[i:0] already includes cin and no separate carry-in level is needed.
module add8_cin
    import byte_serial_adder_pkg::*;
(
    input  byte_t a,
    input  byte_t b,
    input  logic  cin,
    output byte_t sum,
    output logic  cout
);

    byte_t g;
    byte_t p;
    byte_t carry;

    // level 1: pairs
    logic g10, g32, p32, g54, p54, g76, p76;
    // level 2: spans of up to four bits
    logic g20, g30, g64, p64, g74, p74;
    // level 3: spans reaching bit 0
    logic g40, g50, g60, g70;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        g[0] = (a[0] & b[0]) | (p[0] & cin);

        g10 = g[1] | (p[1] & g[0]);
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g54 = g[5] | (p[5] & g[4]);
        p54 = p[5] & p[4];
        g76 = g[7] | (p[7] & g[6]);
        p76 = p[7] & p[6];

        g20 = g[2] | (p[2] & g10);
        g30 = g32  | (p32  & g10);
        g64 = g[6] | (p[6] & g54);
        p64 = p[6] & p54;
        g74 = g76  | (p76  & g54);
        p74 = p76  & p54;

        g40 = g[4] | (p[4] & g30);
        g50 = g54  | (p54  & g30);
        g60 = g64  | (p64  & g30);
        g70 = g74  | (p74  & g30);

        carry = {g60, g50, g40, g30, g20, g10, g[0], cin};
        sum   = p ^ carry;
        cout  = g70;
    end

endmodule

// File: rtl/byte_serial_adder.sv
// byte_serial_adder
//   Adds two NUM_BYTES-wide operands presented one byte pair per beat,
//   least significant byte first, chaining the carry between beats and
//   emitting one registered sum byte per beat.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous abort of the partial frame and any pending result
//   bus   : operand / result streams (see byte_serial_adder_if)
//   busy  : a frame is partially accepted (byte index != 0)
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    byte_serial_adder_if.slave  bus,
    output logic                busy
);

    localparam int               CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    logic [CNT_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    byte_t            out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_carry_q, out_carry_d;

    logic  in_ready;
    logic  accept;
    logic  is_last;
    byte_t add_a;
    byte_t add_b;
    sum_t  add_res;

    add8_cin u_add8_cin (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_res.sum),
        .cout (add_res.cout)
    );

    always_comb begin
        in_ready = !out_valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready && !clear;
        is_last  = (idx_q == LAST_IDX);

        // Operands only reach the adder on an accepted beat, so undriven
        // pins between beats never reach the result registers.
        add_a = accept ? bus.in_a : '0;
        add_b = accept ? bus.in_b : '0;

        idx_d       = idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;

        if (clear) begin
            idx_d       = '0;
            carry_d     = 1'b0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_last_d  = 1'b0;
            out_carry_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_res.sum;
            out_last_d  = is_last;
            out_carry_d = is_last ? add_res.cout : 1'b0;
            // Carry is dropped at the frame boundary so byte 0 always starts clean.
            carry_d     = is_last ? 1'b0 : add_res.cout;
            idx_d       = is_last ? '0 : idx_q + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign busy          = (idx_q != '0);

endmodule
